// File: rtl/sd_write_arbiter.sv
// Two-requester round-robin arbiter that shares one SD controller for 512-byte sector writes.
// Optional watchdog/FAULT state is built only when SD_ARB_TIMEOUT_EN is defined.
module sd_write_arbiter #(
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [7:0]  din0,
    input  logic [7:0]  din1,
    output logic        grant0,
    output logic        grant1,
    output logic        next0,
    output logic        next1,
    input  logic        sd_ready,
    input  logic        sd_ready_for_next_byte,
    output logic        sd_wr,
    output logic [31:0] sd_address,
    output logic [7:0]  sd_din,
    output logic        busy,
    output logic        timeout,
    output logic [2:0]  dbg_state
);

    // Handshake: a sector starts when sd_ready=1 is seen in IDLE; sd_wr is held until the
    // controller drops sd_ready; each cycle sd_ready_for_next_byte=1 in XFER consumes one byte.
`ifdef SD_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_XFER  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_XFER  = 3'd2,
        S_DONE  = 3'd3
    } state_t;
`endif

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [31:0] sd_address_q, sd_address_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        owned;
    logic        byte_pulse;
    logic        unused_bits;

    assign unused_bits = ^{addr0[8:0], addr1[8:0]};

`ifdef SD_ARB_TIMEOUT_EN
    localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES - 1);
    logic [WDW-1:0] wdog_q, wdog_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    assign owned      = (state_q == S_ISSUE) || (state_q == S_XFER) || (state_q == S_DONE);
    assign byte_pulse = (state_q == S_XFER) && sd_ready_for_next_byte;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        sd_address_d = sd_address_q;
        cnt_d        = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (sd_ready && (req0 || req1)) begin
                    // On a tie the requester that was not served last wins.
                    owner_d      = (req0 && req1) ? ~last_q : req1;
                    sd_address_d = owner_d ? {addr1[31:9], 9'b0} : {addr0[31:9], 9'b0};
                    cnt_d        = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!sd_ready) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (sd_ready_for_next_byte) begin
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q == 10'd511) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (sd_ready) begin
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

`ifdef SD_ARB_TIMEOUT_EN
        wdog_d = '0;
        if (owned) begin
            if ((state_d != state_q) || byte_pulse) begin
                wdog_d = '0;
            end else if (wdog_q == WD_LIMIT) begin
                state_d = S_FAULT;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            sd_address_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            sd_address_q <= sd_address_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign timeout = (state_q == S_FAULT);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        grant0 = owned && !owner_q;
        grant1 = owned && owner_q;
        next0  = byte_pulse && !owner_q;
        next1  = byte_pulse && owner_q;
        sd_wr  = (state_q == S_ISSUE);
        sd_din = 8'd0;
        if (state_q == S_XFER) begin
            sd_din = owner_q ? din1 : din0;
        end
    end

    assign sd_address = sd_address_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule
